// File: rtl/pcie_tlp_pkg.sv
// PCIe TLP header definitions shared by the Memory Write TX path: fmt/type codes,
// byte-enable constants and the 3DW/4DW header DW layouts.
package pcie_tlp_pkg;

  localparam logic [2:0] FMT_3DW_DATA = 3'b010;
  localparam logic [2:0] FMT_4DW_DATA = 3'b011;
  localparam logic [4:0] TYPE_MEM     = 5'b00000;
  localparam logic [3:0] BE_ALL       = 4'hF;
  localparam logic [3:0] BE_NONE      = 4'h0;

  typedef struct packed {
    logic [2:0] fmt;
    logic [4:0] typ;
    logic       rsv0;
    logic [2:0] tc;
    logic [3:0] rsv1;
    logic       td;
    logic       ep;
    logic [1:0] attr;
    logic [1:0] at;
    logic [9:0] length;
  } tlp_dw0_t;

  typedef struct packed {
    logic [15:0] req_id;
    logic [7:0]  tag;
    logic [3:0]  last_be;
    logic [3:0]  first_be;
  } tlp_req_dw1_t;

  // Low address DW: H2 of a 3DW header, H3 of a 4DW header
  typedef struct packed {
    logic [29:0] addr_lo;
    logic [1:0]  rsv;
  } tlp_addr_lo_t;

  typedef struct packed {
    logic [61:0] addr;
    logic [9:0]  len;
    logic [15:0] cid;
  } mwr_req_t;

endpackage

// File: rtl/mwr_hdr_gen.sv
// Combinational Memory Write header builder (H0..H3, is_4dw).
// 64-bit addressing only when PCIE_MWR_ADDR64_EN is defined.
module mwr_hdr_gen
  import pcie_tlp_pkg::*;
(
  input  mwr_req_t    req_i,
  output logic [31:0] h0_o,
  output logic [31:0] h1_o,
  output logic [31:0] h2_o,
  output logic [31:0] h3_o,
  output logic        is_4dw_o
);

  tlp_dw0_t     dw0;
  tlp_req_dw1_t dw1;
  tlp_addr_lo_t alo;

  always_comb begin
    dw0          = '0;
    dw0.typ      = TYPE_MEM;
    dw0.length   = req_i.len;
    dw1          = '0;
    dw1.req_id   = req_i.cid;
    dw1.first_be = BE_ALL;
    dw1.last_be  = (req_i.len > 10'd1) ? BE_ALL : BE_NONE;
    alo          = '{addr_lo: req_i.addr[29:0], rsv: 2'b00};
`ifdef PCIE_MWR_ADDR64_EN
    is_4dw_o     = |req_i.addr[61:30];
    dw0.fmt      = is_4dw_o ? FMT_4DW_DATA : FMT_3DW_DATA;
    h2_o         = is_4dw_o ? req_i.addr[61:30] : alo;
    h3_o         = is_4dw_o ? alo : 32'h0;
`else
    is_4dw_o     = 1'b0;
    dw0.fmt      = FMT_3DW_DATA;
    h2_o         = alo;
    h3_o         = 32'h0;
`endif
    h0_o         = dw0;
    h1_o         = dw1;
  end

`ifndef PCIE_MWR_ADDR64_EN
  // Upper address is screened out as a drop before it reaches here
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_i.addr[61:30];
`endif

endmodule

// File: rtl/al_to_axis_pcie_mwr.sv
// Request + payload stream -> 7-series AXIS TX Memory Write TLPs, one TLP per request.
// Define PCIE_MWR_ADDR64_EN to emit 4DW headers for addresses above 4GB.
module al_to_axis_pcie_mwr
  import pcie_tlp_pkg::*;
#(
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      cfg_completer_id,
  input  logic             cfg_bus_master_en,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [61:0]      req_addr,
  input  logic [LEN_W-1:0] req_len,
  input  logic [31:0]      s_wdata,
  input  logic             s_wvalid,
  output logic             s_wready,
  output logic [63:0]      m_axis_tx_tdata,
  output logic [7:0]       m_axis_tx_tkeep,
  output logic             m_axis_tx_tlast,
  output logic             m_axis_tx_tvalid,
  input  logic             m_axis_tx_tready,
  output logic [3:0]       m_axis_tx_tuser,
  output logic             req_err,
  output logic [15:0]      tlp_count
);

  typedef enum logic [1:0] {IDLE, HDR0, HDR1, DATA} state_e;

  state_e           state_q, state_d;
  mwr_req_t         req_q, req_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [31:0]      lo_q, lo_d;
  logic             lo_vld_q, lo_vld_d;
  logic [63:0]      tdata_q, tdata_d;
  logic [7:0]       tkeep_q, tkeep_d;
  logic             tlast_q, tlast_d, tvalid_q, tvalid_d;
  logic             req_err_q, req_err_d;
  logic [15:0]      cnt_q;
  logic [31:0]      h0, h1, h2, h3;
  logic             is_4dw, out_free, accept, drop, addr_hi_bad, wr_hs;
  logic [11:0]      end_dw;

  mwr_hdr_gen u_hdr (.req_i(req_q), .h0_o(h0), .h1_o(h1), .h2_o(h2), .h3_o(h3), .is_4dw_o(is_4dw));

`ifdef PCIE_MWR_ADDR64_EN
  assign addr_hi_bad = 1'b0;
`else
  assign addr_hi_bad = |req_addr[61:30];
  logic unused_h3;
  assign unused_h3 = ^h3;
`endif

  // Dropped requests are still accepted so the requester never stalls on them
  assign end_dw    = 12'(req_addr[9:0]) + 12'(req_len);
  assign drop      = (req_len == '0) || (req_len > LEN_W'(MAX_LEN)) || (end_dw > 12'd1024) || addr_hi_bad;
  assign req_ready = rst_n && cfg_bus_master_en && (state_q == IDLE);
  assign accept    = req_valid && req_ready;
  assign out_free  = !tvalid_q || m_axis_tx_tready;

  always_comb begin
    s_wready = 1'b0;
    if (rem_q != '0) begin
      case (state_q)
        HDR1:    s_wready = !is_4dw && out_free;
        // First DW of a pair parks in lo_q; only a beat-completing DW needs the output slot
        DATA:    s_wready = (!lo_vld_q && rem_q != LEN_W'(1)) || out_free;
        default: s_wready = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    rem_d     = rem_q;
    lo_d      = lo_q;
    lo_vld_d  = lo_vld_q;
    tdata_d   = tdata_q;
    tkeep_d   = tkeep_q;
    tlast_d   = tlast_q;
    tvalid_d  = tvalid_q && !m_axis_tx_tready;
    req_err_d = 1'b0;
    wr_hs     = s_wvalid && s_wready;
    case (state_q)
      IDLE: if (accept) begin
        if (drop) req_err_d = 1'b1;
        else begin
          req_d    = '{addr: req_addr, len: 10'(req_len), cid: cfg_completer_id};
          rem_d    = req_len;
          lo_vld_d = 1'b0;
          state_d  = HDR0;
        end
      end
      HDR0: if (out_free) begin
        tdata_d  = {h1, h0};
        tkeep_d  = 8'hFF;
        tlast_d  = 1'b0;
        tvalid_d = 1'b1;
        state_d  = HDR1;
      end
      HDR1: begin
`ifdef PCIE_MWR_ADDR64_EN
        if (is_4dw) begin
          if (out_free) begin
            tdata_d  = {h3, h2};
            tkeep_d  = 8'hFF;
            tlast_d  = 1'b0;
            tvalid_d = 1'b1;
            state_d  = DATA;
          end
        end else
`endif
        if (wr_hs) begin
          tdata_d  = {s_wdata, h2};
          tkeep_d  = 8'hFF;
          tlast_d  = (rem_q == LEN_W'(1));
          tvalid_d = 1'b1;
          rem_d    = rem_q - LEN_W'(1);
          state_d  = (rem_q == LEN_W'(1)) ? IDLE : DATA;
        end
      end
      DATA: if (wr_hs) begin
        rem_d = rem_q - LEN_W'(1);
        if (lo_vld_q) begin
          tdata_d  = {s_wdata, lo_q};
          tkeep_d  = 8'hFF;
          tlast_d  = (rem_q == LEN_W'(1));
          tvalid_d = 1'b1;
          lo_vld_d = 1'b0;
        end else if (rem_q == LEN_W'(1)) begin
          tdata_d  = {32'h0, s_wdata};
          tkeep_d  = 8'h0F;
          tlast_d  = 1'b1;
          tvalid_d = 1'b1;
        end else begin
          lo_d     = s_wdata;
          lo_vld_d = 1'b1;
        end
        if (rem_q == LEN_W'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      req_q     <= '0;
      rem_q     <= '0;
      lo_q      <= '0;
      lo_vld_q  <= 1'b0;
      tdata_q   <= '0;
      tkeep_q   <= '0;
      tlast_q   <= 1'b0;
      tvalid_q  <= 1'b0;
      req_err_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      rem_q     <= rem_d;
      lo_q      <= lo_d;
      lo_vld_q  <= lo_vld_d;
      tdata_q   <= tdata_d;
      tkeep_q   <= tkeep_d;
      tlast_q   <= tlast_d;
      tvalid_q  <= tvalid_d;
      req_err_q <= req_err_d;
      if (tvalid_q && m_axis_tx_tready && tlast_q) cnt_q <= cnt_q + 16'd1;
    end
  end

  assign m_axis_tx_tdata  = tdata_q;
  assign m_axis_tx_tkeep  = tkeep_q;
  assign m_axis_tx_tlast  = tlast_q;
  assign m_axis_tx_tvalid = tvalid_q;
  assign m_axis_tx_tuser  = 4'b0000;
  assign req_err          = req_err_q;
  assign tlp_count        = cnt_q;

endmodule
